// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer that owns the lab CPU program counter: it walks IDLE -> FETCH -> ISSUE and selects the next PC.
// Optional PC_BOUND_CHECK_EN macro: redirects out-of-range next PCs to FAULT_VECTOR and pulses fault.
module pc_fetch_sequencer #(
  parameter int                  PC_WIDTH     = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  PC_STEP      = 1,
  parameter int                  IMEM_DEPTH   = 384,
  parameter logic [PC_WIDTH-1:0] FAULT_VECTOR = 'h010
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                halt,
  input  logic                stall,
  input  logic                imem_ack,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [PC_WIDTH-1:0] i_pc,
  output logic                instr_valid,
  output logic                running,
  output logic                fault
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

`ifdef PC_BOUND_CHECK_EN
  localparam bit LP_BOUND_EN = 1'b1;
`else
  localparam bit LP_BOUND_EN = 1'b0;
`endif

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_oPc;
  logic [PC_WIDTH-1:0] r_iPc;
  logic                r_imemReq;
  logic                r_instrValid;
  logic                r_running;
  logic                r_fault;

  logic [PC_WIDTH-1:0] w_seqPc;
  logic [PC_WIDTH-1:0] w_selPc;
  logic [PC_WIDTH-1:0] w_nextPc;
  logic                w_outOfRange;
  logic                w_boundFault;

  // Sequential step wraps modulo 2^PC_WIDTH; jump outranks branch.
  assign w_seqPc = r_oPc + PC_WIDTH'(PC_STEP);

  always_comb begin
    w_selPc = w_seqPc;
    if (jump)
      w_selPc = jump_target;
    else if (branch_taken)
      w_selPc = branch_target;
  end

  assign w_outOfRange = 32'(w_selPc) >= 32'(IMEM_DEPTH);
  assign w_boundFault = LP_BOUND_EN && w_outOfRange;
  assign w_nextPc     = w_boundFault ? FAULT_VECTOR : w_selPc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_oPc        <= RESET_PC;
      r_iPc        <= RESET_PC;
      r_imemReq    <= 1'b0;
      r_instrValid <= 1'b0;
      r_running    <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        IDLE, HALTED: begin
          if (start) begin
            r_state      <= FETCH;
            r_imemReq    <= 1'b1;
            r_running    <= 1'b1;
            r_instrValid <= 1'b0;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            r_iPc        <= r_oPc;
            r_state      <= ISSUE;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b1;
          end
        end
        ISSUE: begin
          // A stalled instruction freezes everything, including halt and redirects.
          if (!stall) begin
            r_oPc        <= w_nextPc;
            r_fault      <= w_boundFault;
            r_instrValid <= 1'b0;
            if (halt) begin
              r_state   <= HALTED;
              r_running <= 1'b0;
            end else begin
              r_state   <= FETCH;
              r_imemReq <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req    = r_imemReq;
  assign o_pc        = r_oPc;
  assign i_pc        = r_iPc;
  assign instr_valid = r_instrValid;
  assign running     = r_running;
  assign fault       = r_fault;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: cycle-by-cycle vector table plus hand-written reset sequences.
// Expectations follow PC_BOUND_CHECK_EN when the macro is defined for the build.
module tb_pc_fetch_sequencer;

`ifdef PC_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  // PCs that differ between the checked and unchecked builds.
  localparam logic [8:0] P_JMP1FF = BOUND ? 9'h010 : 9'h1FF;
  localparam logic [8:0] P_WRAP   = BOUND ? 9'h011 : 9'h000;
  localparam logic [8:0] P_JMP180 = BOUND ? 9'h010 : 9'h180;

  typedef struct {
    string      name;
    logic       req;
    logic [8:0] opc;
    logic [8:0] ipc;
    logic       valid;
    logic       run;
    logic       flt;
  } exp_t;

  typedef struct {
    logic       start;
    logic       halt;
    logic       stall;
    logic       ack;
    logic       jump;
    logic [8:0] jt;
    logic       br;
    logic [8:0] bt;
    exp_t       exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       stall = 1'b0;
  logic       imem_ack = 1'b0;
  logic       jump = 1'b0;
  logic [8:0] jump_target = '0;
  logic       branch_taken = 1'b0;
  logic [8:0] branch_target = '0;
  logic       imem_req;
  logic [8:0] o_pc;
  logic [8:0] i_pc;
  logic       instr_valid;
  logic       running;
  logic       fault;

  int   vecCount = 0;
  int   failCount = 0;
  exp_t expQ[$];
  vec_t vecs[$];

  pc_fetch_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .imem_ack(imem_ack), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .o_pc(o_pc), .i_pc(i_pc), .instr_valid(instr_valid),
    .running(running), .fault(fault)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mkExp(string name, logic req, logic [8:0] opc, logic [8:0] ipc,
                                 logic valid, logic run, logic flt);
    exp_t e;
    e.name = name; e.req = req; e.opc = opc; e.ipc = ipc;
    e.valid = valid; e.run = run; e.flt = flt;
    return e;
  endfunction

  function automatic vec_t mkVec(string name, logic st, logic hl, logic sl, logic ak,
                                 logic jp, logic [8:0] jt, logic br, logic [8:0] bt,
                                 logic req, logic [8:0] opc, logic [8:0] ipc,
                                 logic valid, logic run, logic flt);
    vec_t v;
    v.start = st; v.halt = hl; v.stall = sl; v.ack = ak;
    v.jump = jp; v.jt = jt; v.br = br; v.bt = bt;
    v.exp = mkExp(name, req, opc, ipc, valid, run, flt);
    return v;
  endfunction

  task automatic checkOutput();
    exp_t e;
    vecCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard: no expectation queued at %0t", $time);
      return;
    end
    e = expQ.pop_front();
    if (imem_req !== e.req || o_pc !== e.opc || i_pc !== e.ipc ||
        instr_valid !== e.valid || running !== e.run || fault !== e.flt) begin
      failCount++;
      $display("[TB] FAIL %s: got req=%b o_pc=%h i_pc=%h valid=%b run=%b fault=%b, want req=%b o_pc=%h i_pc=%h valid=%b run=%b fault=%b",
               e.name, imem_req, o_pc, i_pc, instr_valid, running, fault,
               e.req, e.opc, e.ipc, e.valid, e.run, e.flt);
    end
  endtask

  // Drives one cycle of inputs, queues the expected post-edge outputs, then checks after the edge.
  task automatic applyStimulus(input vec_t v);
    start = v.start; halt = v.halt; stall = v.stall; imem_ack = v.ack;
    jump = v.jump; jump_target = v.jt; branch_taken = v.br; branch_target = v.bt;
    expQ.push_back(v.exp);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    //           name        st hl sl ak jp jt      br bt      req opc      ipc      vld run flt
    vecs.push_back(mkVec("t1_start",  1,0,0,1, 0,9'h000, 0,9'h000, 1,9'h000,9'h000, 0,1,0));
    vecs.push_back(mkVec("t1_iss0",   0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h000,9'h000, 1,1,0));
    vecs.push_back(mkVec("t1_fet1",   0,0,0,1, 0,9'h000, 0,9'h000, 1,9'h001,9'h000, 0,1,0));
    vecs.push_back(mkVec("t1_iss1",   0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h001,9'h001, 1,1,0));
    vecs.push_back(mkVec("t1_fet2",   0,0,0,1, 0,9'h000, 0,9'h000, 1,9'h002,9'h001, 0,1,0));
    vecs.push_back(mkVec("t1_iss2",   0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h002,9'h002, 1,1,0));
    vecs.push_back(mkVec("t1_fet3",   0,0,0,1, 0,9'h000, 0,9'h000, 1,9'h003,9'h002, 0,1,0));
    vecs.push_back(mkVec("t1_iss3",   0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h003,9'h003, 1,1,0));
    vecs.push_back(mkVec("t1_fet4",   0,0,0,1, 0,9'h000, 0,9'h000, 1,9'h004,9'h003, 0,1,0));
    vecs.push_back(mkVec("t2_wait1",  0,1,0,0, 1,9'h033, 1,9'h044, 1,9'h004,9'h003, 0,1,0));
    vecs.push_back(mkVec("t2_wait2",  0,0,0,0, 0,9'h000, 0,9'h000, 1,9'h004,9'h003, 0,1,0));
    vecs.push_back(mkVec("t2_wait3",  1,0,1,0, 0,9'h000, 0,9'h000, 1,9'h004,9'h003, 0,1,0));
    vecs.push_back(mkVec("t2_ack",    0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h004,9'h004, 1,1,0));
    vecs.push_back(mkVec("t2_fet5",   0,0,0,1, 0,9'h000, 0,9'h000, 1,9'h005,9'h004, 0,1,0));
    vecs.push_back(mkVec("t2_iss5",   0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h005,9'h005, 1,1,0));
    vecs.push_back(mkVec("t3_jmpwin", 0,0,0,0, 1,9'h040, 1,9'h020, 1,9'h040,9'h005, 0,1,0));
    vecs.push_back(mkVec("t3_fetjmp", 0,0,0,1, 1,9'h099, 0,9'h000, 0,9'h040,9'h040, 1,1,0));
    vecs.push_back(mkVec("t3_branch", 0,0,0,0, 0,9'h040, 1,9'h020, 1,9'h020,9'h040, 0,1,0));
    vecs.push_back(mkVec("t4_iss20",  0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h020,9'h020, 1,1,0));
    vecs.push_back(mkVec("t4_jmp7",   0,0,0,0, 1,9'h007, 0,9'h000, 1,9'h007,9'h020, 0,1,0));
    vecs.push_back(mkVec("t4_iss7",   0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h007,9'h007, 1,1,0));
    vecs.push_back(mkVec("t4_stall1", 0,1,1,1, 1,9'h055, 1,9'h066, 0,9'h007,9'h007, 1,1,0));
    vecs.push_back(mkVec("t4_stall2", 1,1,1,0, 0,9'h000, 0,9'h000, 0,9'h007,9'h007, 1,1,0));
    vecs.push_back(mkVec("t4_halt",   0,1,0,0, 0,9'h000, 0,9'h000, 0,9'h008,9'h007, 0,0,0));
    vecs.push_back(mkVec("t4_held",   0,0,0,1, 1,9'h077, 0,9'h000, 0,9'h008,9'h007, 0,0,0));
    vecs.push_back(mkVec("t4_restart",1,0,0,0, 0,9'h000, 0,9'h000, 1,9'h008,9'h007, 0,1,0));
    vecs.push_back(mkVec("t4_fetwait",1,0,0,0, 0,9'h000, 0,9'h000, 1,9'h008,9'h007, 0,1,0));
    vecs.push_back(mkVec("t4_iss8",   0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h008,9'h008, 1,1,0));
    vecs.push_back(mkVec("t5_jmp1ff", 0,0,0,0, 1,9'h1FF, 0,9'h000, 1,P_JMP1FF,9'h008, 0,1,BOUND));
    vecs.push_back(mkVec("t5_iss1ff", 0,0,0,1, 0,9'h000, 0,9'h000, 0,P_JMP1FF,P_JMP1FF, 1,1,0));
    vecs.push_back(mkVec("t5_wrap",   0,0,0,0, 0,9'h000, 0,9'h000, 1,P_WRAP,P_JMP1FF, 0,1,0));
    vecs.push_back(mkVec("t6_issw",   0,0,0,1, 0,9'h000, 0,9'h000, 0,P_WRAP,P_WRAP, 1,1,0));
    vecs.push_back(mkVec("t6_jmp180", 0,0,0,0, 1,9'h180, 0,9'h000, 1,P_JMP180,P_WRAP, 0,1,BOUND));
    vecs.push_back(mkVec("t6_fltdrop",0,0,0,0, 0,9'h000, 0,9'h000, 1,P_JMP180,P_WRAP, 0,1,0));
    vecs.push_back(mkVec("t6_iss180", 0,0,0,1, 0,9'h000, 0,9'h000, 0,P_JMP180,P_JMP180, 1,1,0));
    vecs.push_back(mkVec("t6_jmp17f", 0,0,0,0, 1,9'h17F, 0,9'h000, 1,9'h17F,P_JMP180, 0,1,0));

    #1 reset = 1'b0;
    #1;
    expQ.push_back(mkExp("reset_async", 0, 9'h000, 9'h000, 0, 0, 0));
    checkOutput();
    #1 reset = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset dropped mid-FETCH at 0x1FF must clear outputs before the next edge and mask the later ack.
    applyStimulus(mkVec("r_iss17f",  0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h17F,9'h17F, 1,1,0));
    applyStimulus(mkVec("r_jmp1ff",  0,0,0,0, 1,9'h1FF, 0,9'h000, 1,P_JMP1FF,9'h17F, 0,1,BOUND));
    applyStimulus(mkVec("r_fetwait", 1,0,0,0, 0,9'h000, 0,9'h000, 1,P_JMP1FF,9'h17F, 0,1,0));
    reset = 1'b0;
    #1;
    expQ.push_back(mkExp("r_midfetch", 0, 9'h000, 9'h000, 0, 0, 0));
    checkOutput();
    applyStimulus(mkVec("r_held",    0,0,0,1, 0,9'h000, 0,9'h000, 0,9'h000,9'h000, 0,0,0));
    reset = 1'b1;
    applyStimulus(mkVec("r_ackidle", 0,0,0,1, 1,9'h123, 0,9'h000, 0,9'h000,9'h000, 0,0,0));
    applyStimulus(mkVec("r_start",   1,0,0,0, 0,9'h000, 0,9'h000, 1,9'h000,9'h000, 0,1,0));

    if (expQ.size() != 0) begin
      vecCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover, want 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
